// File: rtl/hlen_extract.sv
// Snoops the packet FIFO write stream, decodes the IPv4 version/IHL byte of each packet,
// and issues a one-cycle HLEN register write (header length in bytes) or an error pulse.
module hlen_extract #(
    parameter logic [15:0] ETH_TYPE = 16'h0800,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_FIFO_n,
    input  logic [63:0]      in_data,
    input  logic [7:0]       in_ctrl,
    input  logic             in_wr,
    output logic             HLEN_Reg_write_en,
    output logic [63:0]      HLEN_in,
    output logic             hdr_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        W1      = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state_q,    state_d;
    logic               wr_en_q,    wr_en_d;
    logic [63:0]        hlen_q,     hlen_d;
    logic               err_q,      err_d;
    logic [CNT_W-1:0]   good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q,  err_cnt_d;

    // Fields of Ethernet word 1: ethertype followed by the first IPv4 byte.
    logic [15:0] ethertype;
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic        is_ctrl;
    logic        hdr_ok;

    assign ethertype = in_data[31:16];
    assign version   = in_data[15:12];
    assign ihl       = in_data[11:8];
    assign is_ctrl   = (in_ctrl != 8'd0);
    assign hdr_ok    = (ethertype == ETH_TYPE) && (version == 4'd4) && (ihl >= 4'd5);

    logic unused_data_bits;
    assign unused_data_bits = ^{in_data[63:32], in_data[7:0]};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        hlen_d     = hlen_q;
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        wr_en_d    = 1'b0;
        err_d      = 1'b0;

        if (in_wr) begin
            unique case (state_q)
                IDLE: begin
                    if (!is_ctrl) begin
                        state_d = W1;
                    end
                end
                W1: begin
                    if (!is_ctrl && hdr_ok) begin
                        hlen_d  = {58'b0, ihl, 2'b00};
                        wr_en_d = 1'b1;
                        if (good_cnt_q != CNT_MAX) begin
                            good_cnt_d = good_cnt_q + CNT_ONE;
                        end
                        state_d = PAYLOAD;
                    end else begin
                        // A control word here is a runt; anything else is a bad header.
                        err_d = 1'b1;
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + CNT_ONE;
                        end
                        state_d = is_ctrl ? IDLE : DROP;
                    end
                end
                PAYLOAD, DROP: begin
                    if (is_ctrl) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_FIFO_n) begin
        if (!rst_FIFO_n) begin
            state_q    <= IDLE;
            wr_en_q    <= 1'b0;
            hlen_q     <= 64'd0;
            err_q      <= 1'b0;
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            hlen_q     <= hlen_d;
            err_q      <= err_d;
            good_cnt_q <= good_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign HLEN_Reg_write_en = wr_en_q;
    assign HLEN_in           = hlen_q;
    assign hdr_err           = err_q;
    assign good_cnt          = good_cnt_q;
    assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_hlen_extract.sv
// Directed, table-driven bench for hlen_extract: one full-width instance plus a 2-bit-counter
// instance fed the same stream so counter saturation is exercised.
module tb_hlen_extract;

    logic        clk = 1'b0;
    logic        rst_FIFO_n;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;

    logic        we,  we2;
    logic [63:0] hlen, hlen2;
    logic        err, err2;
    logic [15:0] good, errc;
    logic [1:0]  good2, errc2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hlen_extract #(.ETH_TYPE(16'h0800), .CNT_W(16)) dut (
        .clk(clk), .rst_FIFO_n(rst_FIFO_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .HLEN_Reg_write_en(we), .HLEN_in(hlen), .hdr_err(err), .good_cnt(good), .err_cnt(errc)
    );

    hlen_extract #(.ETH_TYPE(16'h0800), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_FIFO_n(rst_FIFO_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
        .HLEN_Reg_write_en(we2), .HLEN_in(hlen2), .hdr_err(err2), .good_cnt(good2), .err_cnt(errc2)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  ctrl;
        logic [63:0] data;
        logic        we;
        logic [63:0] hlen;
        logic        err;
        int          good;
        int          errc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_we, input logic [63:0] e_hlen,
                             input logic e_err, input int e_good, input int e_errc);
        int g2 = (e_good > 3) ? 3 : e_good;
        int c2 = (e_errc > 3) ? 3 : e_errc;
        check({tag, " write_en"}, {63'd0, we},  {63'd0, e_we});
        check({tag, " hlen"},     hlen,         e_hlen);
        check({tag, " hdr_err"},  {63'd0, err}, {63'd0, e_err});
        check({tag, " good_cnt"}, {48'd0, good}, 64'(e_good));
        check({tag, " err_cnt"},  {48'd0, errc}, 64'(e_errc));
        check({tag, " sat good"}, {62'd0, good2}, 64'(g2));
        check({tag, " sat err"},  {62'd0, errc2}, 64'(c2));
        check({tag, " sat hlen"}, hlen2,        e_hlen);
    endtask

    // Word with in_wr=1 and the outputs expected right after the edge that samples it.
    task automatic w(input logic [7:0] ctrl, input logic [63:0] data, input logic e_we,
                     input logic [63:0] e_hlen, input logic e_err, input int e_good, input int e_errc);
        vecs.push_back('{1'b1, ctrl, data, e_we, e_hlen, e_err, e_good, e_errc});
    endtask

    // Idle cycle (in_wr=0) with possibly garbage ctrl/data that must be ignored.
    task automatic gap(input logic [7:0] ctrl, input logic [63:0] e_hlen, input int e_good, input int e_errc);
        vecs.push_back('{1'b0, ctrl, 64'h0800_4500_0800_4500, 1'b0, e_hlen, 1'b0, e_good, e_errc});
    endtask

    task automatic drive(input logic wr, input logic [7:0] ctrl, input logic [63:0] data);
        @(negedge clk);
        in_wr   = wr;
        in_ctrl = ctrl;
        in_data = data;
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] W0 = 64'h0011_2233_4455_6677;
    localparam logic [63:0] PL = 64'hDEAD_BEEF_CAFE_F00D;

    initial begin
        // Packet A: two module headers, word0, IHL=5, six payload words, EOP.
        w(8'hFF, 64'h1, 0, 0, 0, 0, 0);
        w(8'h40, 64'h2, 0, 0, 0, 0, 0);
        w(8'h00, W0, 0, 0, 0, 0, 0);
        w(8'h00, 64'hAAAA_BBBB_0800_4500, 1, 20, 0, 1, 0);
        for (int i = 0; i < 6; i++) w(8'h00, PL, 0, 20, 0, 1, 0);
        w(8'h01, PL, 0, 20, 0, 1, 0);
        // Packet B: IHL=15, back-to-back after EOP.
        w(8'h00, W0, 0, 20, 0, 1, 0);
        w(8'h00, 64'h0000_0000_0800_4F00, 1, 60, 0, 2, 0);
        w(8'h01, PL, 0, 60, 0, 2, 0);
        // Packet C: IHL=6, then idle cycles with HLEN held.
        w(8'h00, W0, 0, 60, 0, 2, 0);
        w(8'h00, 64'h0000_0000_0800_4600, 1, 24, 0, 3, 0);
        w(8'h00, PL, 0, 24, 0, 3, 0);
        w(8'h01, PL, 0, 24, 0, 3, 0);
        gap(8'h00, 24, 3, 0);
        gap(8'h00, 24, 3, 0);
        // Reject: IPv6 ethertype; payload that looks like a good word1 is ignored in DROP.
        w(8'h00, W0, 0, 24, 0, 3, 0);
        w(8'h00, 64'h0000_0000_86DD_4500, 0, 24, 1, 3, 1);
        w(8'h00, 64'h0000_0000_0800_4500, 0, 24, 0, 3, 1);
        w(8'h01, PL, 0, 24, 0, 3, 1);
        // Reject: version 6.
        w(8'h00, W0, 0, 24, 0, 3, 1);
        w(8'h00, 64'h0000_0000_0800_6500, 0, 24, 1, 3, 2);
        w(8'h00, PL, 0, 24, 0, 3, 2);
        w(8'h01, PL, 0, 24, 0, 3, 2);
        // Reject: IHL=4.
        w(8'h00, W0, 0, 24, 0, 3, 2);
        w(8'h00, 64'h0000_0000_0800_4400, 0, 24, 1, 3, 3);
        w(8'h02, PL, 0, 24, 0, 3, 3);
        // Runt: EOP (carrying a valid-looking header) in the W1 slot, then a good packet.
        w(8'h00, W0, 0, 24, 0, 3, 3);
        w(8'h01, 64'h0000_0000_0800_4500, 0, 24, 1, 3, 4);
        w(8'h00, W0, 0, 24, 0, 3, 4);
        w(8'h00, 64'h0000_0000_0800_4700, 1, 28, 0, 4, 4);
        w(8'h01, PL, 0, 28, 0, 4, 4);
        // Gaps of 1-3 cycles inside a packet; ctrl garbage during gaps must not end it.
        w(8'h00, W0, 0, 28, 0, 4, 4);
        gap(8'h01, 28, 4, 4);
        gap(8'h00, 28, 4, 4);
        w(8'h00, 64'h0000_0000_0800_4800, 1, 32, 0, 5, 4);
        gap(8'h00, 32, 5, 4);
        w(8'h00, PL, 0, 32, 0, 5, 4);
        gap(8'h01, 32, 5, 4);
        gap(8'h01, 32, 5, 4);
        gap(8'h03, 32, 5, 4);
        w(8'h00, PL, 0, 32, 0, 5, 4);
        w(8'h01, PL, 0, 32, 0, 5, 4);
        w(8'h00, W0, 0, 32, 0, 5, 4);
        w(8'h00, 64'h0000_0000_0800_4500, 1, 20, 0, 6, 4);
        w(8'h01, PL, 0, 20, 0, 6, 4);

        rst_FIFO_n = 1'b0;
        in_wr      = 1'b0;
        in_ctrl    = 8'h00;
        in_data    = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_FIFO_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].ctrl, vecs[i].data);
            check_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].hlen, vecs[i].err,
                      vecs[i].good, vecs[i].errc);
        end

        // Asynchronous reset in the middle of a packet, away from any clock edge.
        drive(1'b1, 8'h00, W0);
        drive(1'b1, 8'h00, 64'h0000_0000_0800_4500);
        check_all("pre-reset word1", 1, 20, 0, 7, 4);
        drive(1'b1, 8'h00, PL);
        drive(1'b0, 8'h00, PL);
        #2;
        rst_FIFO_n = 1'b0;
        #1;
        check_all("async reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_FIFO_n = 1'b1;
        // Abandoned packet: the next data word is word0, so no write and no error yet.
        drive(1'b1, 8'h00, PL);
        check_all("post-reset word0", 0, 0, 0, 0, 0);
        drive(1'b1, 8'h00, 64'h0000_0000_0800_4600);
        check_all("post-reset word1", 1, 24, 0, 1, 0);
        drive(1'b1, 8'h01, PL);
        check_all("post-reset eop", 0, 24, 0, 1, 0);
        drive(1'b0, 8'h00, PL);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hlen_extract.md
# hlen_extract

Header-length extractor sitting directly upstream of the HLEN register in the packet-processing datapath. It snoops the 64-bit packet word stream written into the packet FIFO, tracks packet boundaries, and decodes the IPv4 version/IHL byte. For each valid IPv4 packet it issues a one-cycle write of the header length, in bytes, to the HLEN register. Malformed or non-IPv4 packets are flagged and counted, and never written.

## Interface
Parameters:
- ETH_TYPE, 16'h0800: ethertype accepted as IPv4.
- CNT_W, 16: width of the good-packet and error counters.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_FIFO_n  in  1  asynchronous, active-low reset.
- in_data  in  64  packet word being written to the FIFO.
- in_ctrl  in  8  word control tag:
  - nonzero before the first data word: module header.
  - zero: data word.
  - nonzero after data words: end of packet (EOP).
- in_wr  in  1  in_data/in_ctrl valid this cycle. No backpressure: the block only observes.
- HLEN_Reg_write_en  out  1  one-cycle write strobe to the HLEN register.
- HLEN_in  out  64  header length in bytes, zero-extended. Held between writes.
- hdr_err  out  1  one-cycle pulse when a packet is rejected.
- good_cnt  out  CNT_W  count of packets that produced an HLEN write.
- err_cnt  out  CNT_W  count of rejected packets.

## Operation
- The FSM has four states: IDLE, W1, PAYLOAD, DROP. A cycle with in_wr=0 never changes state or counters.
- IDLE:
  - in_wr with in_ctrl≠0: module header; ignored.
  - in_wr with in_ctrl=0: Ethernet word 0 (DA, SA[47:32]); go to W1.
- W1, next in_wr word:
  - If in_ctrl≠0, the packet ended early (runt): reject, go to IDLE.
  - Otherwise the word carries ethertype = in_data[31:16], version = in_data[15:12], IHL = in_data[11:8].
  - Accept when ethertype==ETH_TYPE, version==4 and IHL≥5. Then set HLEN_in = {58'b0, IHL, 2'b00} (IHL×4), pulse HLEN_Reg_write_en, increment good_cnt, go to PAYLOAD.
  - Otherwise reject and go to DROP.
- PAYLOAD / DROP: consume words until an in_wr word has in_ctrl≠0 (EOP), then go to IDLE. The two states are identical apart from the label; DROP exists for debug visibility.
- Reject means: pulse hdr_err, increment err_cnt. HLEN_in and HLEN_Reg_write_en are unchanged.
- Counters saturate at all-ones; they do not wrap.
- HLEN_Reg_write_en and hdr_err are never asserted in the same cycle.

## Timing
- Reset (rst_FIFO_n=0, asynchronous): state=IDLE; HLEN_Reg_write_en=0, HLEN_in=0, hdr_err=0, good_cnt=0, err_cnt=0. Deassertion is sampled on the next rising clk.
- Latency: the write strobe and HLEN_in update are registered. Both are visible in the cycle after the clk edge that sampled word 1, and HLEN_in is stable in the same cycle the strobe is high.
- Strobe and hdr_err are exactly one cycle wide, even if in_wr stays high.
- Back-to-back packets are supported with no idle cycles. A word with in_ctrl=0 arriving in IDLE on the cycle right after an EOP starts the next packet.
- Reset mid-packet: the partial packet is abandoned with no write and no error count. The next ctrl=0 word after reset is treated as word 0.
- A module-header word (in_ctrl≠0) seen in W1 counts as a runt, not a header.

## Test plan
- Reset, then send 2 module headers, word0, word1 with in_data[31:0]=32'h0800_4500, 6 payload words, and an EOP (ctrl=8'h01). Expect a strobe for 1 cycle after word1 with HLEN_in=64'd20, good_cnt=1, err_cnt=0.
- Send word1 with [31:0]=32'h0800_4F00. Expect HLEN_in=64'd60. Follow with word1 32'h0800_4600. Expect HLEN_in=24 on the second strobe, and HLEN_in held at 24 with no strobe afterwards.
- Reject cases, each giving an hdr_err pulse, no strobe, HLEN_in unchanged and err_cnt+1, with the rest of the packet (including EOP) consumed silently:
  - ethertype 0x86DD.
  - version 6 (32'h0800_6500).
  - IHL=4 (32'h0800_4400).
- Runt: word0, then an EOP word at the W1 position. Expect hdr_err=1, FSM back in IDLE, and the following valid packet writes HLEN normally.
- Back-to-back packets with an EOP immediately followed by word0, and with in_wr gaps of 1–3 cycles inside packets. Expect exactly one strobe per packet and correct HLEN values.
- Assert rst_FIFO_n low asynchronously (mid-cycle) while in PAYLOAD. Expect all outputs 0 immediately; after release the next packet yields a correct HLEN; good_cnt restarts from 0.
